and_cascade_checker: RTL and testbench

AND_CASCADE_CHECKER -- requirements
Module: and_cascade_checker

---
 rtl/and_cascade_checker_pkg.sv | 17 +
 rtl/and_cascade_checker_tag_delay_line.sv | 39 +++
 rtl/and_cascade_checker.sv | 132 +++++++++++++
 tb/tb_and_cascade_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/and_cascade_checker_pkg.sv
// Shared definitions for the AND-cascade sweep checker.
// State encodings are fixed so firmware/debug views can decode the state register.
package and_cascade_checker_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned MaxLatency = 15;

    // Drain counter width covers every legal LATENCY.
    localparam int unsigned DrainCntW = 4;

endpackage

// File: rtl/and_cascade_checker_tag_delay_line.sv
// Fixed-depth register pipeline carrying {valid, expected, stimulus} tags.
// Depth 0 degenerates to a wire so the compare sees the current cycle.
module tag_delay_line #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic [Width-1:0] i_data,
    output logic [Width-1:0] o_data
);

    generate
        if (Depth == 0) begin : g_pass
            logic w_unused;
            assign w_unused = i_clk ^ i_reset ^ i_clear;
            assign o_data   = i_data;
        end else begin : g_pipe
            logic [Width-1:0] r_stage [Depth];

            always_ff @(posedge i_clk) begin
                if (i_reset || i_clear) begin
                    for (int i = 0; i < Depth; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < Depth; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[Depth-1];
        end
    endgenerate

endmodule

// File: rtl/and_cascade_checker.sv
// Exhaustive sweep checker for an LENGTH-input AND cascade: drives every input
// pattern, compares the (optionally delayed) response and records the outcome.
module and_cascade_checker
    import and_cascade_checker_pkg::*;
#(
    parameter int unsigned LENGTH  = 8,
    parameter int unsigned LATENCY = 0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    output logic [LENGTH-1:0] o_stimulus,
    input  logic              i_response,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [LENGTH:0]   o_error_count,
    output logic [LENGTH-1:0] o_first_fail
);

    localparam int unsigned          TagW      = LENGTH + 2;
    localparam logic [LENGTH-1:0]    StimMax   = {LENGTH{1'b1}};
    localparam logic [DrainCntW-1:0] DrainLast =
        DrainCntW'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_e                 r_state;
    logic [LENGTH-1:0]      r_stimulus;
    logic [LENGTH-1:0]      r_first_fail;
    logic [LENGTH:0]        r_error_count;
    logic [DrainCntW-1:0]   r_drain_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;

    logic                   w_start_ok;
    logic                   w_mismatch;
    logic                   w_exp_valid;
    logic                   w_exp_value;
    logic [LENGTH-1:0]      w_exp_stim;
    logic [TagW-1:0]        w_tag_in;
    logic [TagW-1:0]        w_tag_out;
    logic [LENGTH:0]        w_error_next;

    assign w_start_ok = i_start && ((r_state == StIdle) || (r_state == StDone));
    assign w_tag_in   = {r_state == StDrive, &r_stimulus, r_stimulus};

    tag_delay_line #(
        .Width (TagW),
        .Depth (LATENCY)
    ) u_tag_delay_line (
        .i_clk   (i_clock),
        .i_reset (i_reset),
        .i_clear (w_start_ok),
        .i_data  (w_tag_in),
        .o_data  (w_tag_out)
    );

    assign {w_exp_valid, w_exp_value, w_exp_stim} = w_tag_out;
    assign w_mismatch   = w_exp_valid && (i_response != w_exp_value);
    assign w_error_next = r_error_count + {{LENGTH{1'b0}}, w_mismatch};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_stimulus  <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state    <= StDrive;
                        r_stimulus <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end
                StDrive: begin
                    if (r_stimulus == StimMax) begin
                        r_stimulus  <= '0;
                        r_drain_cnt <= '0;
                        if (LATENCY == 0) begin
                            // Last sample is compared on this same edge.
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_error_next == '0);
                        end else begin
                            r_state <= StDrain;
                        end
                    end else begin
                        r_stimulus <= r_stimulus + 1'b1;
                    end
                end
                StDrain: begin
                    if (r_drain_cnt == DrainLast) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_error_next == '0);
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || w_start_ok) begin
            r_error_count <= '0;
            r_first_fail  <= '0;
        end else if (w_mismatch) begin
            r_error_count <= w_error_next;
            if (r_error_count == '0) begin
                r_first_fail <= w_exp_stim;
            end
        end
    end

    assign o_stimulus    = r_stimulus;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_error_count = r_error_count;
    assign o_first_fail  = r_first_fail;

endmodule

// File: tb/tb_and_cascade_checker.sv
// Drives two checkers (LATENCY 0 with a combinational cascade, LATENCY 2 with a
// two-stage registered cascade) through ideal, stuck and randomly faulted sweeps.
module tb_and_cascade_checker;

    localparam int unsigned L = 8;
    localparam int unsigned N = 1 << L;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   mode;       // 0: cascade with flip faults, 1: stuck 0, 2: stuck 1
    logic [N-1:0] flip_vec;

    logic [L-1:0] stim0, stim1, ff0, ff1;
    logic [L:0]   err0, err1;
    logic         resp0, resp1, busy0, busy1, done0, done1, pass0, pass1;
    logic         ideal1, pipe_a, pipe_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        resp0 = 1'b0;
        if (mode == 2'd1)      resp0 = 1'b0;
        else if (mode == 2'd2) resp0 = 1'b1;
        else                   resp0 = (stim0 == 8'hFF) ^ flip_vec[stim0];
    end

    always_comb begin
        ideal1 = 1'b0;
        if (mode == 2'd1)      ideal1 = 1'b0;
        else if (mode == 2'd2) ideal1 = 1'b1;
        else                   ideal1 = (stim1 == 8'hFF) ^ flip_vec[stim1];
    end

    always @(posedge clk) begin
        pipe_a <= ideal1;
        pipe_b <= pipe_a;
    end
    assign resp1 = pipe_b;

    and_cascade_checker #(.LENGTH(L), .LATENCY(0)) u_dut0 (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .o_stimulus    (stim0),
        .i_response    (resp0),
        .o_busy        (busy0),
        .o_done        (done0),
        .o_pass        (pass0),
        .o_error_count (err0),
        .o_first_fail  (ff0)
    );

    and_cascade_checker #(.LENGTH(L), .LATENCY(2)) u_dut1 (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .o_stimulus    (stim1),
        .i_response    (resp1),
        .o_busy        (busy1),
        .o_done        (done1),
        .o_pass        (pass1),
        .o_error_count (err1),
        .o_first_fail  (ff1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: walk every input pattern, expected = all-ones pattern only.
    task automatic model(output int exp_err, output int exp_ff);
        logic r;
        exp_err = 0;
        exp_ff  = 0;
        for (int v = 0; v < N; v++) begin
            if (mode == 2'd1)      r = 1'b0;
            else if (mode == 2'd2) r = 1'b1;
            else                   r = (v == N - 1) ^ flip_vec[v];
            if (r != (v == N - 1)) begin
                if (exp_err == 0) exp_ff = v;
                exp_err++;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input int restart_at);
        int cyc0 = 0;
        int cyc1 = 0;
        int seq_bad = 0;
        int guard = 0;
        int exp_err;
        int exp_ff;
        model(exp_err, exp_ff);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (!(done0 && done1) && guard < 2000) begin
            if (busy0) begin
                if (cyc0 < N && int'(stim0) != cyc0) seq_bad++;
                cyc0++;
            end
            if (busy1) begin
                if (cyc1 < N && int'(stim1) != cyc1) seq_bad++;
                cyc1++;
            end
            start = (restart_at >= 0) && busy0 && (int'(stim0) == restart_at);
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " finished"}, int'(done0 && done1), 1);
        check({tag, " stim seq"}, seq_bad, 0);
        check({tag, " busy cycles L0"}, cyc0, N);
        check({tag, " busy cycles L2"}, cyc1, N + 2);
        check({tag, " err L0"}, int'(err0), exp_err);
        check({tag, " ff L0"}, int'(ff0), exp_ff);
        check({tag, " pass L0"}, int'(pass0), int'(exp_err == 0));
        check({tag, " err L2"}, int'(err1), exp_err);
        check({tag, " ff L2"}, int'(ff1), exp_ff);
        check({tag, " pass L2"}, int'(pass1), int'(exp_err == 0));
        repeat (3) @(negedge clk);
        check({tag, " hold err"}, int'(err0), exp_err);
        check({tag, " hold done"}, int'(done0 && done1 && !busy0 && !busy1), 1);
        check({tag, " stim idle"}, int'(stim0) + int'(stim1), 0);
    endtask

    initial begin
        int guard;
        rst      = 1'b1;
        start    = 1'b1;
        mode     = 2'd0;
        flip_vec = '0;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("reset stim", int'(stim0), 0);
        check("reset flags", int'({busy0, done0, pass0, busy1, done1, pass1}), 0);
        check("reset err", int'(err0) + int'(err1), 0);
        check("reset ff", int'(ff0) + int'(ff1), 0);

        run_sweep("ideal", -1);
        mode = 2'd1;
        run_sweep("stuck0", -1);
        mode = 2'd2;
        run_sweep("stuck1", -1);

        mode = 2'd0;
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < N; v++) flip_vec[v] = ($urandom_range(0, 15) == 0);
            if (k == 2) flip_vec[N-1] = 1'b1;
            run_sweep($sformatf("rand%0d", k), (k == 1) ? 16 : -1);
        end

        // Abort mid-sweep with reset and start together.
        flip_vec    = '0;
        flip_vec[5] = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        guard = 0;
        while (stim0 != 8'h40 && guard < 400) begin
            guard++;
            @(negedge clk);
        end
        check("reach 0x40", int'(stim0), 'h40);
        check("err before abort", int'(err0), 1);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("abort stim", int'(stim0) + int'(stim1), 0);
        check("abort flags", int'({busy0, done0, pass0, busy1, done1, pass1}), 0);
        check("abort err/ff", int'(err0) + int'(ff0) + int'(err1) + int'(ff1), 0);
        @(negedge clk);
        check("still idle", int'(busy0 || busy1), 0);
        run_sweep("after reset", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
